// File: rtl/bsg_axil_demux_n.sv
// N-way AXI4-Lite address demux: one subordinate port fanned out to num_ports_p manager ports
// by base/mask decode, with DECERR for unmapped addresses. Independent single-outstanding write and read paths.
module bsg_axil_demux_n #(
  parameter int num_ports_p  = 4,
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter logic [num_ports_p*addr_width_p-1:0] base_addr_p =
    {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
  parameter logic [num_ports_p*addr_width_p-1:0] addr_mask_p =
    {4{32'hF000_0000}}
) (
  input  logic                                       aclk,
  input  logic                                       aresetn,

  input  logic [addr_width_p-1:0]                    s_axil_awaddr,
  input  logic [2:0]                                 s_axil_awprot,
  input  logic                                       s_axil_awvalid,
  output logic                                       s_axil_awready,
  input  logic [data_width_p-1:0]                    s_axil_wdata,
  input  logic [(data_width_p/8)-1:0]                s_axil_wstrb,
  input  logic                                       s_axil_wvalid,
  output logic                                       s_axil_wready,
  output logic [1:0]                                 s_axil_bresp,
  output logic                                       s_axil_bvalid,
  input  logic                                       s_axil_bready,
  input  logic [addr_width_p-1:0]                    s_axil_araddr,
  input  logic [2:0]                                 s_axil_arprot,
  input  logic                                       s_axil_arvalid,
  output logic                                       s_axil_arready,
  output logic [data_width_p-1:0]                    s_axil_rdata,
  output logic [1:0]                                 s_axil_rresp,
  output logic                                       s_axil_rvalid,
  input  logic                                       s_axil_rready,

  output logic [num_ports_p*addr_width_p-1:0]        m_axil_awaddr,
  output logic [num_ports_p*3-1:0]                   m_axil_awprot,
  output logic [num_ports_p-1:0]                     m_axil_awvalid,
  input  logic [num_ports_p-1:0]                     m_axil_awready,
  output logic [num_ports_p*data_width_p-1:0]        m_axil_wdata,
  output logic [num_ports_p*(data_width_p/8)-1:0]    m_axil_wstrb,
  output logic [num_ports_p-1:0]                     m_axil_wvalid,
  input  logic [num_ports_p-1:0]                     m_axil_wready,
  input  logic [num_ports_p*2-1:0]                   m_axil_bresp,
  input  logic [num_ports_p-1:0]                     m_axil_bvalid,
  output logic [num_ports_p-1:0]                     m_axil_bready,
  output logic [num_ports_p*addr_width_p-1:0]        m_axil_araddr,
  output logic [num_ports_p*3-1:0]                   m_axil_arprot,
  output logic [num_ports_p-1:0]                     m_axil_arvalid,
  input  logic [num_ports_p-1:0]                     m_axil_arready,
  input  logic [num_ports_p*data_width_p-1:0]        m_axil_rdata,
  input  logic [num_ports_p*2-1:0]                   m_axil_rresp,
  input  logic [num_ports_p-1:0]                     m_axil_rvalid,
  output logic [num_ports_p-1:0]                     m_axil_rready
);

  localparam int strb_width_lp = data_width_p / 8;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_FWD = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FWD = 2'd1, R_RESP = 2'd2} r_state_e;

  // One-hot port select; the lowest-index matching window wins, all-zero means unmapped.
  function automatic logic [num_ports_p-1:0] decode_f(input logic [addr_width_p-1:0] addr);
    logic [num_ports_p-1:0] oh;
    logic                   found;
    logic                   match;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < num_ports_p; i++) begin
      match = ((addr & addr_mask_p[i*addr_width_p +: addr_width_p]) ==
               (base_addr_p[i*addr_width_p +: addr_width_p] & addr_mask_p[i*addr_width_p +: addr_width_p]));
      oh[i] = match & ~found;
      found = found | match;
    end
    return oh;
  endfunction

  w_state_e                    w_state_q, w_state_d;
  logic [addr_width_p-1:0]     aw_addr_q, aw_addr_d;
  logic [2:0]                  aw_prot_q, aw_prot_d;
  logic [data_width_p-1:0]     w_data_q, w_data_d;
  logic [strb_width_lp-1:0]    w_strb_q, w_strb_d;
  logic                        aw_have_q, aw_have_d, w_have_q, w_have_d;
  logic                        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                        aw_rdy_q, aw_rdy_d, w_rdy_q, w_rdy_d;
  logic [num_ports_p-1:0]      w_sel_q, w_sel_d;
  logic [1:0]                  bresp_q, bresp_d;

  r_state_e                    r_state_q, r_state_d;
  logic [addr_width_p-1:0]     ar_addr_q, ar_addr_d;
  logic [2:0]                  ar_prot_q, ar_prot_d;
  logic                        ar_have_q, ar_have_d, ar_done_q, ar_done_d;
  logic                        ar_rdy_q, ar_rdy_d;
  logic [num_ports_p-1:0]      r_sel_q, r_sel_d;
  logic [data_width_p-1:0]     rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;

  logic                        w_fwd_s, m_aw_hs_s, m_w_hs_s, m_b_hit_s;
  logic                        r_fwd_s, m_ar_hs_s, m_rrdy_s, m_r_hit_s;
  logic [1:0]                  bresp_mux_s, rresp_mux_s;
  logic [data_width_p-1:0]     rdata_mux_s;

  assign w_fwd_s   = (w_state_q == W_FWD);
  assign m_aw_hs_s = w_fwd_s & ~aw_done_q & (|(m_axil_awready & w_sel_q));
  assign m_w_hs_s  = w_fwd_s & ~w_done_q & (|(m_axil_wready & w_sel_q));
  assign m_b_hit_s = w_fwd_s & (|(m_axil_bvalid & w_sel_q));

  assign r_fwd_s   = (r_state_q == R_FWD);
  assign m_ar_hs_s = r_fwd_s & ~ar_done_q & (|(m_axil_arready & r_sel_q));
  // R is accepted as early as the AR handshake cycle so a zero-wait manager costs no extra cycle.
  assign m_rrdy_s  = r_fwd_s & (ar_done_q | m_ar_hs_s);
  assign m_r_hit_s = m_rrdy_s & (|(m_axil_rvalid & r_sel_q));

  // Response selection from the active manager port.
  always_comb begin
    bresp_mux_s = 2'b00;
    rresp_mux_s = 2'b00;
    rdata_mux_s = '0;
    for (int i = 0; i < num_ports_p; i++) begin
      bresp_mux_s = bresp_mux_s | ({2{w_sel_q[i]}} & m_axil_bresp[i*2 +: 2]);
      rresp_mux_s = rresp_mux_s | ({2{r_sel_q[i]}} & m_axil_rresp[i*2 +: 2]);
      rdata_mux_s = rdata_mux_s | ({data_width_p{r_sel_q[i]}} & m_axil_rdata[i*data_width_p +: data_width_p]);
    end
  end

  // Write path next-state logic.
  always_comb begin
    w_state_d = w_state_q;
    aw_addr_d = aw_addr_q;
    aw_prot_d = aw_prot_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    w_sel_d   = w_sel_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_axil_awvalid && aw_rdy_q) begin
          aw_addr_d = s_axil_awaddr;
          aw_prot_d = s_axil_awprot;
          aw_have_d = 1'b1;
        end else begin
          aw_have_d = aw_have_q;
        end
        if (s_axil_wvalid && w_rdy_q) begin
          w_data_d = s_axil_wdata;
          w_strb_d = s_axil_wstrb;
          w_have_d = 1'b1;
        end else begin
          w_have_d = w_have_q;
        end
        if (aw_have_q && w_have_q) begin
          w_sel_d   = decode_f(aw_addr_q);
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (|w_sel_d) begin
            w_state_d = W_FWD;
          end else begin
            w_state_d = W_RESP;
            bresp_d   = 2'b11;
          end
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_FWD: begin
        aw_done_d = aw_done_q | m_aw_hs_s;
        w_done_d  = w_done_q | m_w_hs_s;
        if (aw_done_d && w_done_d && m_b_hit_s) begin
          bresp_d   = bresp_mux_s;
          w_state_d = W_RESP;
        end else begin
          w_state_d = W_FWD;
        end
      end
      W_RESP: begin
        if (s_axil_bready) begin
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
    aw_rdy_d = (w_state_d == W_IDLE) & ~aw_have_d;
    w_rdy_d  = (w_state_d == W_IDLE) & ~w_have_d;
  end

  // Write path state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      aw_addr_q <= '0;
      aw_prot_q <= 3'b000;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      aw_rdy_q  <= 1'b0;
      w_rdy_q   <= 1'b0;
      w_sel_q   <= '0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      aw_addr_q <= aw_addr_d;
      aw_prot_q <= aw_prot_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      aw_rdy_q  <= aw_rdy_d;
      w_rdy_q   <= w_rdy_d;
      w_sel_q   <= w_sel_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read path next-state logic.
  always_comb begin
    r_state_d = r_state_q;
    ar_addr_d = ar_addr_q;
    ar_prot_d = ar_prot_q;
    ar_have_d = ar_have_q;
    ar_done_d = ar_done_q;
    r_sel_d   = r_sel_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axil_arvalid && ar_rdy_q) begin
          ar_addr_d = s_axil_araddr;
          ar_prot_d = s_axil_arprot;
          ar_have_d = 1'b1;
        end else begin
          ar_have_d = ar_have_q;
        end
        if (ar_have_q) begin
          r_sel_d   = decode_f(ar_addr_q);
          ar_have_d = 1'b0;
          ar_done_d = 1'b0;
          if (|r_sel_d) begin
            r_state_d = R_FWD;
          end else begin
            r_state_d = R_RESP;
            rdata_d   = '0;
            rresp_d   = 2'b11;
          end
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_FWD: begin
        ar_done_d = ar_done_q | m_ar_hs_s;
        if (m_r_hit_s) begin
          rdata_d   = rdata_mux_s;
          rresp_d   = rresp_mux_s;
          r_state_d = R_RESP;
        end else begin
          r_state_d = R_FWD;
        end
      end
      R_RESP: begin
        if (s_axil_rready) begin
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_RESP;
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
    ar_rdy_d = (r_state_d == R_IDLE) & ~ar_have_d;
  end

  // Read path state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      ar_addr_q <= '0;
      ar_prot_q <= 3'b000;
      ar_have_q <= 1'b0;
      ar_done_q <= 1'b0;
      ar_rdy_q  <= 1'b0;
      r_sel_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      ar_addr_q <= ar_addr_d;
      ar_prot_q <= ar_prot_d;
      ar_have_q <= ar_have_d;
      ar_done_q <= ar_done_d;
      ar_rdy_q  <= ar_rdy_d;
      r_sel_q   <= r_sel_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axil_awready = aw_rdy_q;
  assign s_axil_wready  = w_rdy_q;
  assign s_axil_bvalid  = (w_state_q == W_RESP);
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = ar_rdy_q;
  assign s_axil_rvalid  = (r_state_q == R_RESP);
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

  // Unselected ports see zeros on every field, not just on the handshake bits.
  for (genvar i = 0; i < num_ports_p; i++) begin : g_port
    assign m_axil_awaddr[i*addr_width_p +: addr_width_p]   = w_sel_q[i] ? aw_addr_q : '0;
    assign m_axil_awprot[i*3 +: 3]                         = w_sel_q[i] ? aw_prot_q : 3'b000;
    assign m_axil_awvalid[i]                               = w_fwd_s & ~aw_done_q & w_sel_q[i];
    assign m_axil_wdata[i*data_width_p +: data_width_p]    = w_sel_q[i] ? w_data_q : '0;
    assign m_axil_wstrb[i*strb_width_lp +: strb_width_lp]  = w_sel_q[i] ? w_strb_q : '0;
    assign m_axil_wvalid[i]                                = w_fwd_s & ~w_done_q & w_sel_q[i];
    assign m_axil_bready[i]                                = w_fwd_s & w_sel_q[i];
    assign m_axil_araddr[i*addr_width_p +: addr_width_p]   = r_sel_q[i] ? ar_addr_q : '0;
    assign m_axil_arprot[i*3 +: 3]                         = r_sel_q[i] ? ar_prot_q : 3'b000;
    assign m_axil_arvalid[i]                               = r_fwd_s & ~ar_done_q & r_sel_q[i];
    assign m_axil_rready[i]                                = m_rrdy_s & r_sel_q[i];
  end

endmodule
